// File: rtl/tt_pkg.sv
// Shared types and default sizing for the truth-table evaluation engine.
package tt_pkg;

  localparam int unsigned TT_N_IN_DEF  = 3;
  localparam int unsigned TT_N_OUT_DEF = 2;

  typedef enum logic [1:0] {
    TT_LOAD  = 2'd0,
    TT_RUN   = 2'd1,
    TT_DRAIN = 2'd2
  } tt_state_t;

endpackage

// File: rtl/tt_mem.sv
// Truth-table storage: 2^N_IN words of N_OUT bits, synchronous write and clear,
// combinational read.
module tt_mem #(
  parameter int unsigned N_IN  = tt_pkg::TT_N_IN_DEF,
  parameter int unsigned N_OUT = tt_pkg::TT_N_OUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [N_IN-1:0]  i_waddr,
  input  logic [N_OUT-1:0] i_wdata,
  input  logic [N_IN-1:0]  i_raddr,
  output logic [N_OUT-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << N_IN;

  logic [N_OUT-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tt_eval_engine.sv
// Truth-table evaluation engine: LOAD/RUN/DRAIN control around tt_mem with a
// one-deep registered result stage. Optional eval_cnt output under TT_EVCNT_EN.
module tt_eval_engine #(
  parameter int unsigned N_IN  = tt_pkg::TT_N_IN_DEF,
  parameter int unsigned N_OUT = tt_pkg::TT_N_OUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             cfg_start,
  input  logic             cfg_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] f,
  output logic [1:0]       state
`ifdef TT_EVCNT_EN
  ,
  output logic [15:0]      eval_cnt
`endif
);

  import tt_pkg::*;

  tt_state_t        r_state;
  tt_state_t        w_state_nxt;
  logic             r_out_valid;
  logic [N_OUT-1:0] r_f;
  logic [N_OUT-1:0] w_rdata;
  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_tbl_we;

  // A cfg_start seen in RUN blocks inputs in the same cycle it arrives.
  assign in_ready = !rst && (r_state == TT_RUN) && !cfg_start &&
                    (!r_out_valid || out_ready);
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;
  assign w_tbl_we = cfg_we && (r_state == TT_LOAD);

  tt_mem #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_tbl_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_raddr (x),
    .o_rdata (w_rdata)
  );

  // DRAIN also exits when nothing is pending, so a start that coincides with
  // an output handshake cannot leave the FSM waiting forever.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TT_LOAD:  if (cfg_done) w_state_nxt = TT_RUN;
      TT_RUN:   if (cfg_start) w_state_nxt = r_out_valid ? TT_DRAIN : TT_LOAD;
      TT_DRAIN: if (!r_out_valid || w_out_hs) w_state_nxt = TT_LOAD;
      default:  w_state_nxt = TT_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TT_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_f         <= '0;
    end else if (w_in_hs) begin
      r_out_valid <= 1'b1;
      r_f         <= w_rdata;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign f         = r_f;
  assign state     = r_state;

`ifdef TT_EVCNT_EN
  logic [15:0] r_eval_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_eval_cnt <= '0;
    end else if (w_out_hs && (r_eval_cnt != '1)) begin
      r_eval_cnt <= r_eval_cnt + 16'd1;
    end
  end

  assign eval_cnt = r_eval_cnt;
`endif

endmodule

// File: tb/tb_tt_eval_engine.sv
// Directed self-checking bench for tt_eval_engine (defaults N_IN=3, N_OUT=2);
// counter checks are built only when TT_EVCNT_EN is defined.
module tb_tt_eval_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [1:0] cfg_data;
  logic       cfg_start;
  logic       cfg_done;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] x;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] f;
  logic [1:0] state;
`ifdef TT_EVCNT_EN
  logic [15:0] eval_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  tt_eval_engine #(
    .N_IN  (3),
    .N_OUT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_start (cfg_start),
    .cfg_done  (cfg_done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .state     (state)
`ifdef TT_EVCNT_EN
    ,
    .eval_cnt  (eval_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] vec_x [4];
  logic [1:0] vec_f [4];

  initial begin
    vec_x[0] = 3'd1; vec_f[0] = 2'b01;
    vec_x[1] = 3'd2; vec_f[1] = 2'b11;
    vec_x[2] = 3'd7; vec_f[2] = 2'b10;
    vec_x[3] = 3'd0; vec_f[3] = 2'b00;

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_start = 1'b0; cfg_done = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;

    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("load_ign_start", 32'(state), 32'd0);
    cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    chk("run_entry", 32'(state), 32'd1);

    // First evaluation on an all-zero table
    in_valid = 1'b1; x = 3'd5; out_ready = 1'b1;
    #1 chk("run_rdy", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    chk("x5_ov", 32'(out_valid), 32'd1);
    chk("x5_f", 32'(f), 32'd0);
    tick();
    chk("ov_clear", 32'(out_valid), 32'd0);

    cfg_start = 1'b1;
    #1 chk("start_blocks", 32'(in_ready), 32'd0);
    tick(); cfg_start = 1'b0;
    chk("run_to_load", 32'(state), 32'd0);

    cfg_we = 1'b1;
    cfg_addr = 3'd1; cfg_data = 2'b01; tick();
    cfg_addr = 3'd2; cfg_data = 2'b11; tick();
    cfg_addr = 3'd7; cfg_data = 2'b10; tick();
    cfg_we = 1'b0; cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    chk("run_again", 32'(state), 32'd1);

    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = vec_x[i];
      tick();
      chk($sformatf("stream%0d_f", i), 32'(f), 32'(vec_f[i]));
      chk($sformatf("stream%0d_ov", i), 32'(out_valid), 32'd1);
    end

    // Backpressure: result f=00 pending, next input x=2 waiting
    out_ready = 1'b0; x = 3'd2;
    #1 chk("stall_rdy0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_f", i), 32'(f), 32'd0);
      chk($sformatf("stall%0d_ov", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_rdy", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("release_rdy", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    chk("release_f", 32'(f), 32'd3);
    chk("release_ov", 32'(out_valid), 32'd1);

    // Write attempt in RUN must be ignored; then drain a pending result
    out_ready = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 2'b00; tick(); cfg_we = 1'b0;
    cfg_start = 1'b1;
    #1 chk("drain_start_rdy", 32'(in_ready), 32'd0);
    tick(); cfg_start = 1'b0;
    chk("drain_state", 32'(state), 32'd2);
    chk("drain_rdy", 32'(in_ready), 32'd0);
    chk("drain_f", 32'(f), 32'd3);
    cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    chk("drain_ign_done", 32'(state), 32'd2);
    out_ready = 1'b1; tick();
    chk("drain_to_load", 32'(state), 32'd0);
    chk("drain_ov", 32'(out_valid), 32'd0);

    // Write coinciding with cfg_done
    cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 2'b11; cfg_done = 1'b1;
    tick(); cfg_we = 1'b0; cfg_done = 1'b0;
    chk("we_done_state", 32'(state), 32'd1);
    in_valid = 1'b1; x = 3'd4; tick();
    chk("x4_f", 32'(f), 32'd3);
    x = 3'd2; tick();
    chk("run_we_ignored", 32'(f), 32'd3);
    x = 3'd1; tick();
    chk("table_kept", 32'(f), 32'd1);
    in_valid = 1'b0;

    // Reset with a pending result and conflicting inputs
    rst = 1'b1; cfg_start = 1'b1; in_valid = 1'b1;
    tick(); rst = 1'b0; cfg_start = 1'b0; in_valid = 1'b0;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_f", 32'(f), 32'd0);
    cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    in_valid = 1'b1; x = 3'd2; tick(); in_valid = 1'b0;
    chk("tbl_cleared_f", 32'(f), 32'd0);
    chk("tbl_cleared_ov", 32'(out_valid), 32'd1);

`ifdef TT_EVCNT_EN
    rst = 1'b1; tick(); rst = 1'b0;
    chk("cnt_rst", 32'(eval_cnt), 32'd0);
    cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; x = 3'd3;
    for (int i = 0; i < 100; i++) tick();
    chk("cnt_99", 32'(eval_cnt), 32'd99);
    for (int i = 0; i < 69900; i++) tick();
    chk("cnt_sat", 32'(eval_cnt), 32'hFFFF);
    rst = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0;
    chk("cnt_rst2", 32'(eval_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_eval_engine.md
TT_EVAL_ENGINE -- requirements
Module: tt_eval_engine

Interface
REQ-001 SHALL have parameter N_IN, default 3, number of Boolean inputs (1..8).
REQ-002 SHALL have parameter N_OUT, default 2, number of Boolean outputs (1..16).
REQ-003 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cfg_we, input, 1, table-entry write strobe.
REQ-006 SHALL have port cfg_addr, input, N_IN, minterm index to write.
REQ-007 SHALL have port cfg_data, input, N_OUT, output bits for that minterm (bit k = f_k).
REQ-008 SHALL have port cfg_start, input, 1, pulse requesting entry to LOAD.
REQ-009 SHALL have port cfg_done, input, 1, pulse ending LOAD.
REQ-010 SHALL have port in_valid, input, 1, input vector valid.
REQ-011 SHALL have port in_ready, output, 1, input vector accepted when in_valid and in_ready are both high.
REQ-012 SHALL have port x, input, N_IN, input vector (x[0] = x0).
REQ-013 SHALL have port out_valid, output, 1, result valid.
REQ-014 SHALL have port out_ready, input, 1, result consumed when out_valid and out_ready are both high.
REQ-015 SHALL have port f, output, N_OUT, registered result.
REQ-016 SHALL have port state, output, 2, current FSM state (for debug).

Function
REQ-017 SHALL hold a truth table of 2^N_IN entries, each N_OUT bits wide; f_k(x) = table[x][k].
REQ-018 SHALL implement states LOAD=0, RUN=1 and DRAIN=2; encoding 3 is unreachable and SHALL recover to LOAD.
REQ-019 SHALL, in LOAD, write table[cfg_addr] <= cfg_data on cfg_we, hold in_ready=0, and move to RUN on cfg_done.
REQ-020 SHALL, when cfg_we and cfg_done fall in the same LOAD cycle, commit the write and still enter RUN.
REQ-021 SHALL ignore cfg_we in RUN and DRAIN.
REQ-022 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-023 SHALL, on an input handshake, load f <= table[x] and set out_valid=1 at the next edge (latency 1 cycle, one result per cycle sustained).
REQ-024 SHALL hold f and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL clear out_valid after an output handshake that has no accompanying input handshake in the same cycle.
REQ-026 SHALL, on cfg_start in RUN, refuse further inputs from that cycle on and go to LOAD if out_valid=0, otherwise to DRAIN.
REQ-027 SHALL, in DRAIN, hold in_ready=0 and go to LOAD on the cycle the pending output handshakes.
REQ-028 SHALL ignore cfg_start in LOAD and DRAIN, and SHALL ignore cfg_done outside LOAD.
REQ-029 SHALL leave table contents unchanged across LOAD entry; only written entries change.

Reset
REQ-030 SHALL, on rst, set state=LOAD, every table entry=0, f=0, out_valid=0 and in_ready=0.
REQ-031 SHALL let rst override every other input in the same cycle, including mid-LOAD and mid-DRAIN; any pending result is discarded.

Configuration
REQ-032 SHALL, with TT_EVCNT_EN defined, add output eval_cnt[15:0]: it resets to 0, increments on each output handshake and saturates at 16'hFFFF.
REQ-033 SHALL, without TT_EVCNT_EN, have no eval_cnt port and no counter logic.

Structure
REQ-034 SHALL place the state enum (tt_state_t) and the N_IN/N_OUT default constants in shared package tt_pkg.
REQ-035 SHALL place table storage in sub-module tt_mem: synchronous write port, combinational read port, synchronous clear on rst.

Verification
REQ-036 Reset, then cfg_done, then x=5 -> f=0, out_valid=1 one cycle after the input handshake.
REQ-037 In LOAD, write addr 1 = 2'b01, addr 2 = 2'b11, addr 7 = 2'b10, then cfg_done; stream x=1,2,7,0 with out_ready=1 -> f=01,11,10,00 on four consecutive cycles.
REQ-038 Hold out_ready=0 for 3 cycles with a result pending -> f stable, in_ready=0; raising out_ready -> next input accepted in that same cycle.
REQ-039 Assert cfg_start while out_valid=1 and out_ready=0 -> state=DRAIN, in_ready=0; output handshake -> state=LOAD on the next cycle; cfg_we in RUN has no effect on the table.
REQ-040 Assert cfg_we (addr 4, data 2'b11) together with cfg_done, then x=4 -> f=2'b11.
REQ-041 With TT_EVCNT_EN defined, 70000 output handshakes -> eval_cnt=16'hFFFF; rst -> eval_cnt=0.
